// File: rtl/iob_sram2p_rd_stream_pkg.sv
// Shared types and constants for the 2-port SRAM read-stream engine.
package iob_sram2p_rd_stream_pkg;

   localparam int DEF_AW    = 12;
   localparam int DEF_DW    = 256;
   localparam int BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

endpackage

// File: rtl/iob_sram2p_rd_stream_if.sv
// Command, SRAM read port and output stream of the read-stream engine.
interface iob_sram2p_rd_stream_if
   import iob_sram2p_rd_stream_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW,
   parameter int LW = AW + 1
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          enb;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          done;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, doutb, m_ready,
      output cmd_ready, enb, addrb, m_valid, m_data, m_last, busy, done
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, doutb, m_ready,
      input  cmd_ready, enb, addrb, m_valid, m_data, m_last, busy, done
   );
endinterface

// File: rtl/iob_fifo2.sv
// Two-entry synchronous FIFO; the head word stays stable until it is popped.
module iob_fifo2
   import iob_sram2p_rd_stream_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   output logic [DW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [1:0]    count_o
);
   logic [DW-1:0] mem_q [BUF_DEPTH];
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(pop_i && empty_o));
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == 2'(BUF_DEPTH));
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
endmodule

// File: rtl/iob_sram2p_rd_stream.sv
// Streams {addr,len} reads out of a 2-port SRAM onto a valid/ready bus with last.
module iob_sram2p_rd_stream
   import iob_sram2p_rd_stream_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW,
   parameter int LW = AW + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   iob_sram2p_rd_stream_if.master  bus
);
   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [LW-1:0] out_rem_q, out_rem_d;
   logic          inflight_q;

   logic          pop;
   logic          issue;
   logic [2:0]    occupancy;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0]    fifo_count;
   logic [DW-1:0] fifo_dout;

   // A word returning from the SRAM goes straight out when the buffer is empty
   // and the consumer takes it; otherwise it is parked in the buffer.
   assign pop        = bus.m_valid && bus.m_ready;
   assign fifo_pop   = pop && !fifo_empty;
   assign fifo_push  = inflight_q && !(fifo_empty && pop);
   assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
   assign issue      = (state_q == ST_RUN) && (rem_q != '0) && (occupancy < 3'(BUF_DEPTH));

   assign bus.enb       = issue;
   assign bus.addrb     = addr_q;
   assign bus.m_valid   = inflight_q || !fifo_empty;
   assign bus.m_data    = !bus.m_valid ? '0 : (fifo_empty ? bus.doutb : fifo_dout);
   assign bus.m_last    = bus.m_valid && (out_rem_q == LW'(1));
   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_FIN);

   iob_fifo2 #(.DW(DW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   (bus.doutb),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      out_rem_d = pop ? out_rem_q - LW'(1) : out_rem_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               addr_d    = bus.cmd_addr;
               rem_d     = bus.cmd_len;
               out_rem_d = bus.cmd_len;
               state_d   = (bus.cmd_len == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d = addr_q + AW'(1);
               rem_d  = rem_q - LW'(1);
               if (rem_q == LW'(1)) state_d = ST_DRAIN;
            end
         end
         // Every issued word is accounted for once the final beat is taken.
         ST_DRAIN: if (out_rem_d == '0) state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         out_rem_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         out_rem_q  <= out_rem_d;
         inflight_q <= issue;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(fifo_push && fifo_full && !fifo_pop));
   end
endmodule

// File: tb/tb_iob_sram2p_rd_stream.sv
// Directed bench for iob_sram2p_rd_stream with a one-cycle-latency SRAM model.
module tb_iob_sram2p_rd_stream;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int LW = 13;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   iob_sram2p_rd_stream_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
   iob_sram2p_rd_stream #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      return {8'hD5, a, ~a};
   endfunction

   always @(posedge clk) if (bus.enb) bus.doutb <= data_of(bus.addrb);

   int checks = 0;
   int errors = 0;

   int            enb_off[$];
   logic [AW-1:0] enb_adr[$];
   int            beat_off[$];
   logic [DW-1:0] beat_dat[$];
   logic          beat_last[$];
   int            done_off, done_cnt, occ_viol, stab_viol, ghost_last;
   logic          acc_ready, ready_after, busy1, timed_out;

   // Issues one command and records per-cycle activity relative to the accept cycle.
   task automatic run_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input int mode, input int max_cyc);
      int issued, accepted;
      logic prev_stall, pop;
      logic [DW-1:0] prev_data;
      bit fin;
      enb_off.delete(); enb_adr.delete();
      beat_off.delete(); beat_dat.delete(); beat_last.delete();
      issued = 0; accepted = 0; prev_stall = 0; prev_data = '0; fin = 0;
      done_off = -1; done_cnt = 0; occ_viol = 0; stab_viol = 0; ghost_last = 0;
      busy1 = 0; ready_after = 0;
      bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_len = len; bus.m_ready = 1'b1;
      @(negedge clk);
      acc_ready = bus.cmd_ready;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      for (int k = 1; k <= max_cyc && !fin; k++) begin
         bus.m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         @(negedge clk);
         pop = bus.m_valid && bus.m_ready;
         if (bus.enb) begin
            if (issued - accepted - int'(pop) >= 2) occ_viol++;
            enb_off.push_back(k);
            enb_adr.push_back(bus.addrb);
         end
         if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stab_viol++;
         if (pop) begin
            beat_off.push_back(k);
            beat_dat.push_back(bus.m_data);
            beat_last.push_back(bus.m_last);
         end
         if (bus.m_last && !bus.m_valid) ghost_last++;
         if (k == 1) busy1 = bus.busy;
         if (done_off >= 0 && k == done_off + 1) begin
            ready_after = bus.cmd_ready;
            fin = 1;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_off < 0) done_off = k;
         end
         issued += int'(bus.enb);
         accepted += int'(pop);
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data = bus.m_data;
         @(posedge clk); #1;
      end
      bus.m_ready = 1'b1;
      timed_out = !fin;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
      checks++; if (bus.enb !== 1'b0) begin errors++; $display("FAIL reset_enb got=%b exp=0", bus.enb); end
      checks++; if (bus.addrb !== '0) begin errors++; $display("FAIL reset_addrb got=%h exp=0", bus.addrb); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
      checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", bus.m_last); end
      checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      $display("reset: cmd_ready=%b busy=%b m_valid=%b", bus.cmd_ready, bus.busy, bus.m_valid);
      @(posedge clk); #1;
   endtask

   task automatic test_burst4;
      int bad;
      run_cmd(12'h010, 13'd4, 0, 50);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL burst4_timeout got=%b exp=0", timed_out); end
      checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL burst4_accept got=%b exp=1", acc_ready); end
      checks++; if (enb_off.size() != 4) begin errors++; $display("FAIL burst4_enb_count got=%0d exp=4", enb_off.size()); end
      bad = 0;
      foreach (enb_off[i]) if (enb_off[i] != i + 1 || enb_adr[i] !== 12'(16'h010 + i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL burst4_enb_seq got=%0d bad exp=0", bad); end
      checks++; if (beat_off.size() != 4) begin errors++; $display("FAIL burst4_beats got=%0d exp=4", beat_off.size()); end
      bad = 0;
      foreach (beat_off[i])
         if (beat_off[i] != i + 2 || beat_dat[i] !== data_of(12'(16'h010 + i)) || beat_last[i] !== (i == 3)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL burst4_beat_seq got=%0d bad exp=0", bad); end
      checks++; if (done_off != 6) begin errors++; $display("FAIL burst4_done_cycle got=%0d exp=6", done_off); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL burst4_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (ghost_last != 0) begin errors++; $display("FAIL burst4_last_without_valid got=%0d exp=0", ghost_last); end
      $display("burst4: enb=%0d beats=%0d done@T+%0d", enb_off.size(), beat_off.size(), done_off);
   endtask

   task automatic test_wrap;
      logic [AW-1:0] exp_adr[4];
      logic [AW-1:0] got;
      exp_adr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      run_cmd(12'hFFE, 13'd4, 0, 50);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL wrap_timeout got=%b exp=0", timed_out); end
      for (int i = 0; i < 4; i++) begin
         got = (i < enb_adr.size()) ? enb_adr[i] : 12'hxxx;
         checks++; if (got !== exp_adr[i]) begin errors++; $display("FAIL wrap_addrb[%0d] got=%h exp=%h", i, got, exp_adr[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= beat_dat.size() || beat_dat[i] !== data_of(exp_adr[i])) begin
            errors++;
            $display("FAIL wrap_data[%0d] got=%h exp=%h", i, (i < beat_dat.size()) ? beat_dat[i] : 'x, data_of(exp_adr[i]));
         end
      end
      $display("wrap: enb=%0d beats=%0d", enb_adr.size(), beat_dat.size());
   endtask

   task automatic test_backpressure;
      int bad, last_off;
      run_cmd(12'h100, 13'd8, 1, 200);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
      checks++; if (enb_off.size() != 8) begin errors++; $display("FAIL bp_enb_count got=%0d exp=8", enb_off.size()); end
      checks++; if (beat_off.size() != 8) begin errors++; $display("FAIL bp_beats got=%0d exp=8", beat_off.size()); end
      bad = 0;
      foreach (beat_dat[i]) if (beat_dat[i] !== data_of(12'(16'h100 + i)) || beat_last[i] !== (i == 7)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_data_order got=%0d bad exp=0", bad); end
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stab_viol); end
      checks++; if (occ_viol != 0) begin errors++; $display("FAIL bp_occupancy got=%0d exp=0", occ_viol); end
      last_off = (beat_off.size() > 0) ? beat_off[beat_off.size() - 1] : -10;
      checks++; if (done_off != last_off + 1) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=%0d", done_off, last_off + 1); end
      $display("backpressure: beats=%0d last@T+%0d done@T+%0d", beat_off.size(), last_off, done_off);
   endtask

   task automatic test_len0;
      run_cmd(12'h123, 13'd0, 0, 20);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL len0_timeout got=%b exp=0", timed_out); end
      checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL len0_accept got=%b exp=1", acc_ready); end
      checks++; if (enb_off.size() != 0) begin errors++; $display("FAIL len0_enb got=%0d exp=0", enb_off.size()); end
      checks++; if (beat_off.size() != 0) begin errors++; $display("FAIL len0_beats got=%0d exp=0", beat_off.size()); end
      checks++; if (done_off != 1) begin errors++; $display("FAIL len0_done_cycle got=%0d exp=1", done_off); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL len0_busy got=%b exp=1", busy1); end
      checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL len0_ready_T2 got=%b exp=1", ready_after); end
      $display("len0: done@T+%0d cmd_ready@T+2=%b", done_off, ready_after);
   endtask

   task automatic test_reset_mid;
      int beats, k, dones, vals;
      bus.cmd_valid = 1'b1; bus.cmd_addr = 12'h200; bus.cmd_len = 13'd6; bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      beats = 0; k = 0;
      while (beats < 2 && k < 20) begin
         @(negedge clk);
         if (bus.m_valid && bus.m_ready) beats++;
         @(posedge clk); #1;
         k++;
      end
      checks++; if (beats != 2) begin errors++; $display("FAIL rstmid_two_beats got=%0d exp=2", beats); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got=%b exp=1", bus.cmd_ready); end
      checks++; if (bus.enb !== 1'b0) begin errors++; $display("FAIL rstmid_enb got=%b exp=0", bus.enb); end
      checks++; if (bus.addrb !== '0) begin errors++; $display("FAIL rstmid_addrb got=%h exp=0", bus.addrb); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got=%b exp=0", bus.m_valid); end
      checks++; if (bus.m_data !== '0 || bus.m_last !== 1'b0) begin errors++; $display("FAIL rstmid_m_data got=%h last=%b exp=0", bus.m_data, bus.m_last); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      dones = int'(bus.done); vals = 0;
      repeat (6) begin
         @(posedge clk); #1;
         @(negedge clk);
         dones += int'(bus.done);
         vals += int'(bus.m_valid);
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
      checks++; if (vals != 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", vals); end
      @(posedge clk); #1;
      run_cmd(12'h300, 13'd1, 0, 20);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rstmid_fresh_timeout got=%b exp=0", timed_out); end
      checks++; if (beat_off.size() != 1) begin errors++; $display("FAIL rstmid_fresh_beats got=%0d exp=1", beat_off.size()); end
      checks++;
      if (beat_off.size() < 1 || beat_dat[0] !== data_of(12'h300) || beat_last[0] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_fresh_word got=%h exp=%h with last", (beat_dat.size() > 0) ? beat_dat[0] : 'x, data_of(12'h300));
      end
      checks++; if (done_off != 3) begin errors++; $display("FAIL rstmid_fresh_done got=%0d exp=3", done_off); end
      $display("reset_mid: dones_after_rst=%0d fresh beats=%0d done@T+%0d", dones, beat_off.size(), done_off);
   endtask

   task automatic test_full_depth;
      int adr_bad, dat_bad, gap_bad, last_cnt;
      run_cmd(12'h000, 13'h1000, 0, 4200);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL full_timeout got=%b exp=0", timed_out); end
      checks++; if (enb_off.size() != 4096) begin errors++; $display("FAIL full_enb_count got=%0d exp=4096", enb_off.size()); end
      checks++; if (beat_off.size() != 4096) begin errors++; $display("FAIL full_beats got=%0d exp=4096", beat_off.size()); end
      adr_bad = 0; dat_bad = 0; gap_bad = 0; last_cnt = 0;
      foreach (enb_adr[i]) if (enb_adr[i] !== 12'(i)) adr_bad++;
      foreach (beat_dat[i]) begin
         if (beat_dat[i] !== data_of(12'(i))) dat_bad++;
         if (beat_off[i] != i + 2) gap_bad++;
         if (beat_last[i] === 1'b1) last_cnt++;
      end
      checks++; if (adr_bad != 0) begin errors++; $display("FAIL full_addr_seq got=%0d bad exp=0", adr_bad); end
      checks++; if (dat_bad != 0) begin errors++; $display("FAIL full_data_seq got=%0d bad exp=0", dat_bad); end
      checks++; if (gap_bad != 0) begin errors++; $display("FAIL full_throughput got=%0d gaps exp=0", gap_bad); end
      checks++;
      if (last_cnt != 1 || beat_last.size() != 4096 || beat_last[4095] !== 1'b1) begin
         errors++;
         $display("FAIL full_last got=%0d lasts exp=1 on beat 4096", last_cnt);
      end
      checks++; if (done_off != 4098) begin errors++; $display("FAIL full_done_cycle got=%0d exp=4098", done_off); end
      $display("full_depth: beats=%0d lasts=%0d done@T+%0d", beat_off.size(), last_cnt, done_off);
   endtask

   initial begin
      test_reset();
      test_burst4();
      test_wrap();
      test_backpressure();
      test_len0();
      test_reset_mid();
      test_full_depth();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iob_sram2p_rd_stream.md
Name: iob_sram2p_rd_stream

Overview:
- Read-side engine for the 2-port IOB SRAM. Drives the read port (enb/addrb) and consumes doutb, which is valid one cycle after enb.
- Accepts one {base address, length} command at a time. Streams the words out on a valid/ready master interface with a last flag.
- Absorbs the SRAM read latency and downstream backpressure with a 2-entry buffer. Sustains 1 word/clk when m_ready is held high.

Parameters:
- AW, 12, SRAM address width (depth 2**AW words)
- DW, 256, SRAM data width
- LW, AW+1, command length width; allows a full-depth transfer of 2**AW words

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; high only in IDLE
- cmd_addr  in  AW  first word address
- cmd_len  in  LW  number of words; 0 means no reads
- enb  out  1  SRAM read enable
- addrb  out  AW  SRAM read address
- doutb  in  DW  SRAM read data, valid the cycle after enb
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DW  output word
- m_last  out  1  final word of the command
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (sync, active-high) forces:
  - state to IDLE; cmd_ready=1
  - enb=0, addrb=0
  - m_valid=0, m_last=0, m_data=0
  - busy=0, done=0
  - buffer count 0, inflight 0, remaining 0
- Reset asserted mid-transfer: buffered words and any in-flight read are discarded. No done pulse.
- States:
  - IDLE: on cmd_valid&cmd_ready, latch addr and len. If len==0, go to FIN; else go to RUN.
  - RUN: issue reads. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until buffer is empty, inflight==0, and the last beat has been accepted; then go to FIN.
  - FIN: done=1 for exactly one cycle, then return to IDLE.
- Read issue, combinational, in RUN only:
  - enb = (remaining!=0) && (buf_count + inflight - pop < 2), where pop = m_valid&m_ready this cycle.
  - addrb = current address.
  - On enb: address increments modulo 2**AW (wraps 0xFFF->0x000 at AW=12) and remaining decrements.
  - inflight <= enb, registered.
- Capture: when inflight==1, push doutb into the buffer that cycle. The issue rule guarantees the buffer never overflows; overflow is an assertion failure.
- Output:
  - m_valid/m_data come from the buffer head.
  - m_data must hold stable while m_valid&&!m_ready.
  - m_last=1 on the word whose index is len-1.
  - Push and pop in the same cycle are both honoured.
- Latency (cmd handshake in cycle T, m_ready=1):
  - first enb in T+1
  - first m_valid in T+2
  - N words leave in cycles T+2..T+N+1
  - done in the cycle after the m_last handshake
- len==0: no enb, no m_valid; done pulses in T+1.
- Commands offered while busy are not accepted (cmd_ready=0). A new command may be accepted in the cycle after done.

Decomposition:
- Shared package holds the state encoding constants (IDLE, RUN, DRAIN, FIN) and the buffer depth constant (2).
- One sub-module: iob_fifo2, a 2-entry synchronous FIFO with push/pop, full/empty and count, parameterised on DW, using the same clk/rst.
- The top level keeps the FSM, address/length counters and issue logic.

Test Plan:
- addr=0x010, len=4, m_ready=1:
  - enb high cycles T+1..T+4, addrb 0x010..0x013
  - 4 beats in consecutive cycles, m_last on the 4th
  - done one cycle after the 4th beat
- addr=0xFFE, len=4: addrb sequence 0xFFE, 0xFFF, 0x000, 0x001; data order matches SRAM contents.
- len=8, m_ready toggling 1,0,0,1,...:
  - no word lost or duplicated
  - m_data stable while stalled
  - enb never asserted when buf_count+inflight would exceed 2
- len=0: cmd accepted, zero enb, zero m_valid, done pulse in T+1, cmd_ready back high in T+2.
- rst asserted after beat 2 of len=6: all outputs at reset values the next cycle, no done. A fresh len=1 command afterwards completes normally.
- len=4096 at addr=0, m_ready=1:
  - 4096 beats, m_last only on beat 4096
  - addrb wraps to 0 once
  - throughput 1 word/clk after the first beat
